// File: rtl/plab4_net_router_input_unit.sv
// Input stage of one ring-router port: a circular-buffer FIFO that stores each
// message together with its output route, computed once at enqueue time.
module plab4_net_router_input_unit #(
  parameter int p_payload_nbits = 8,
  parameter int p_opaque_nbits  = 8,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_routers   = 8,
  parameter int p_num_entries   = 2
) (
  input  logic                                                     clk,
  input  logic                                                     reset,
  input  logic                                                     in_val,
  output logic                                                     in_rdy,
  input  logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] in_msg,
  output logic                                                     out_val,
  input  logic                                                     out_rdy,
  output logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0] out_msg,
  output logic [1:0]                                               out_port,
  output logic [$clog2(p_num_entries+1)-1:0]                       num_entries
);

  localparam int MSG_NBITS = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits;
  localparam int CNT_NBITS = $clog2(p_num_entries+1);
  localparam int PTR_NBITS = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int DEST_LSB  = p_payload_nbits + p_opaque_nbits + p_srcdest_nbits;
  localparam int RW        = p_srcdest_nbits + 1;

  localparam logic [1:0] PORT_DEC  = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_INC  = 2'd2;

  localparam logic [RW-1:0]        ID_W     = RW'(p_router_id);
  localparam logic [RW-1:0]        N_W      = RW'(p_num_routers);
  localparam logic [RW-1:0]        HALF_W   = RW'(p_num_routers / 2);
  localparam logic [PTR_NBITS-1:0] LAST_PTR = PTR_NBITS'(p_num_entries - 1);
  localparam logic [CNT_NBITS-1:0] FULL_CNT = CNT_NBITS'(p_num_entries);

  // Handshake: a transfer happens on a rising edge where val && rdy; rdy and
  // val are driven purely from registered occupancy, never from the partner.
  logic                 enq;
  logic                 deq;
  logic [CNT_NBITS-1:0] count;
  logic [PTR_NBITS-1:0] enq_ptr;
  logic [PTR_NBITS-1:0] deq_ptr;

  logic [MSG_NBITS-1:0] msg_mem  [p_num_entries];
  logic [1:0]           port_mem [p_num_entries];

  logic [RW-1:0] dest;
  logic [RW-1:0] fwd_raw;
  logic [RW-1:0] fwd;
  logic [1:0]    route;

  // dest < N and id < N keep dest + N - id inside [1, 2N-1], which fits RW bits.
  always_comb begin
    dest    = {1'b0, in_msg[DEST_LSB +: p_srcdest_nbits]};
    fwd_raw = dest + N_W - ID_W;
    fwd     = (fwd_raw >= N_W) ? fwd_raw - N_W : fwd_raw;
    route   = PORT_DEC;
    if (dest >= N_W || dest == ID_W) begin
      route = PORT_TERM;
    end else if (fwd <= HALF_W) begin
      route = PORT_INC;
    end
  end

  function automatic logic [PTR_NBITS-1:0] incr_ptr(input logic [PTR_NBITS-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy      = (count != FULL_CNT);
  assign out_val     = (count != '0);
  assign enq         = in_val && in_rdy;
  assign deq         = out_val && out_rdy;
  assign out_msg     = msg_mem[deq_ptr];
  assign out_port    = port_mem[deq_ptr];
  assign num_entries = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      enq_ptr <= '0;
      deq_ptr <= '0;
    end else begin
      if (enq) enq_ptr <= incr_ptr(enq_ptr);
      if (deq) deq_ptr <= incr_ptr(deq_ptr);
      if (enq && !deq) begin
        count <= count + 1'b1;
      end else if (deq && !enq) begin
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      msg_mem[enq_ptr]  <= in_msg;
      port_mem[enq_ptr] <= route;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_unit.sv
// Bench for the router input unit: two instances (id 2 of 8, id 0 of 5),
// randomized traffic checked against a queue-based reference model.
module tb_plab4_net_router_input_unit;

  localparam int PB = 8, OB = 8, SB = 3;
  localparam int M = PB + OB + 2*SB;
  localparam int W = M + 2;
  localparam int DEPTH = 2;
  localparam int ID_A = 2, N_A = 8;
  localparam int ID_B = 0, N_B = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         in_val_a, in_rdy_a, out_val_a, out_rdy_a;
  logic [M-1:0] in_msg_a, out_msg_a;
  logic [1:0]   out_port_a, num_entries_a;
  logic         in_val_b, in_rdy_b, out_val_b, out_rdy_b;
  logic [M-1:0] in_msg_b, out_msg_b;
  logic [1:0]   out_port_b, num_entries_b;

  plab4_net_router_input_unit #(
    .p_payload_nbits(PB), .p_opaque_nbits(OB), .p_srcdest_nbits(SB),
    .p_router_id(ID_A), .p_num_routers(N_A), .p_num_entries(DEPTH)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_val(in_val_a), .in_rdy(in_rdy_a), .in_msg(in_msg_a),
    .out_val(out_val_a), .out_rdy(out_rdy_a), .out_msg(out_msg_a),
    .out_port(out_port_a), .num_entries(num_entries_a)
  );

  plab4_net_router_input_unit #(
    .p_payload_nbits(PB), .p_opaque_nbits(OB), .p_srcdest_nbits(SB),
    .p_router_id(ID_B), .p_num_routers(N_B), .p_num_entries(DEPTH)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg_b),
    .out_val(out_val_b), .out_rdy(out_rdy_b), .out_msg(out_msg_b),
    .out_port(out_port_b), .num_entries(num_entries_b)
  );

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_total = 0;
  int n_pass  = 0;
  int sink_mode_a = 0;  // 0 = hold low, 1 = hold high, 2 = random
  int sink_max = 3;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Route from the ring rules: terminal for self or malformed, else the
  // shorter way round, ties going toward increasing id.
  function automatic logic [1:0] route_of(input int d, input int id, input int n);
    int fwd;
    if (d >= n || d == id) return 2'd1;
    fwd = ((d - id) % n + n) % n;
    return (fwd <= n / 2) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [M-1:0] mk_msg(input int d, input int s, input int o, input int p);
    logic [SB-1:0] dd, ss;
    logic [OB-1:0] oo;
    logic [PB-1:0] pp;
    dd = SB'(d); ss = SB'(s); oo = OB'(o); pp = PB'(p);
    return {dd, ss, oo, pp};
  endfunction

  // Monitors: model occupancy is the queue size; acceptance and consumption
  // are decided from the model, and DUT outputs are checked against it.
  always @(negedge clk) begin : mon_a
    int occ;
    logic [W-1:0] e;
    if (reset) begin
      occ = exp_q_a.size();
      check("a_num_entries", 32'(num_entries_a), 32'(occ));
      check("a_out_val", 32'(out_val_a), 32'(occ != 0));
      check("a_in_rdy", 32'(in_rdy_a), 32'(occ != DEPTH));
      if (out_rdy_a && occ != 0) begin
        e = exp_q_a.pop_front();
        check("a_out_msg", 32'(out_msg_a), 32'(e[W-1:2]));
        check("a_out_port", 32'(out_port_a), 32'(e[1:0]));
      end
      if (in_val_a && occ != DEPTH)
        exp_q_a.push_back({in_msg_a, route_of(int'(in_msg_a[M-1 -: SB]), ID_A, N_A)});
    end
  end

  always @(negedge clk) begin : mon_b
    int occ;
    logic [W-1:0] e;
    if (reset) begin
      occ = exp_q_b.size();
      check("b_num_entries", 32'(num_entries_b), 32'(occ));
      check("b_out_val", 32'(out_val_b), 32'(occ != 0));
      if (out_rdy_b && occ != 0) begin
        e = exp_q_b.pop_front();
        check("b_out_msg", 32'(out_msg_b), 32'(e[W-1:2]));
        check("b_out_port", 32'(out_port_b), 32'(e[1:0]));
      end
      if (in_val_b && occ != DEPTH)
        exp_q_b.push_back({in_msg_b, route_of(int'(in_msg_b[M-1 -: SB]), ID_B, N_B)});
    end
  end

  initial begin
    out_rdy_a = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (sink_mode_a)
        0:       out_rdy_a = 1'b0;
        1:       out_rdy_a = 1'b1;
        default: out_rdy_a = ($urandom_range(0, sink_max) == 0);
      endcase
    end
  end

  task automatic send_a(input logic [M-1:0] msg, input int gap);
    logic acc;
    int guard;
    in_val_a = 1'b1;
    in_msg_a = msg;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_rdy_a;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("a_send_timeout", 32'(0), 32'(1));
    in_val_a = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_b(input logic [M-1:0] msg);
    logic acc;
    int guard;
    in_val_b = 1'b1;
    in_msg_b = msg;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_rdy_b;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("b_send_timeout", 32'(0), 32'(1));
    in_val_b = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", 32'(exp_q_a.size() + exp_q_b.size()), 32'(0));
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rt_dest[7] = '{2, 3, 4, 6, 7, 0, 1};
    int b_dest[3]  = '{6, 3, 2};
    in_val_a = 1'b0; in_msg_a = '0;
    in_val_b = 1'b0; in_msg_b = '0; out_rdy_b = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_a_out_val", 32'(out_val_a), 32'(0));
    check("rst_a_in_rdy", 32'(in_rdy_a), 32'(1));
    check("rst_a_num", 32'(num_entries_a), 32'(0));
    check("rst_b_out_val", 32'(out_val_b), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Route table for id 2 of 8
    sink_mode_a = 1;
    foreach (rt_dest[i])
      send_a(mk_msg(rt_dest[i], $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255)), 0);
    drain();

    // Back-pressure: third message waits until the consumer drains one
    sink_mode_a = 0;
    @(posedge clk); #1;
    send_a(mk_msg(5, 1, 8'h10, 8'h01), 0);
    send_a(mk_msg(1, 2, 8'h11, 8'h02), 0);
    fork
      send_a(mk_msg(3, 3, 8'h12, 8'h03), 0);
      begin
        repeat (3) @(negedge clk);
        check("bp_full_num", 32'(num_entries_a), 32'(2));
        check("bp_full_rdy", 32'(in_rdy_a), 32'(0));
        sink_mode_a = 1;
      end
    join
    drain();

    // Streaming with opaque sequence 0..7
    sink_mode_a = 1;
    for (int i = 0; i < 8; i++)
      send_a(mk_msg($urandom_range(0, 7), $urandom_range(0, 7), i, $urandom_range(0, 255)), 0);
    drain();

    // Random source/sink delays in both balances
    sink_mode_a = 2;
    sink_max = 10;
    for (int i = 0; i < 25; i++)
      send_a(mk_msg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                    $urandom_range(0, 255)), $urandom_range(0, 3));
    sink_max = 3;
    for (int i = 0; i < 25; i++)
      send_a(mk_msg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                    $urandom_range(0, 255)), $urandom_range(0, 10));
    sink_mode_a = 1;
    drain();

    // Five-router ring at id 0: malformed and boundary destinations, then random
    foreach (b_dest[i]) send_b(mk_msg(b_dest[i], 4, 8'h5A + i, 8'hC3 - i));
    for (int i = 0; i < 12; i++)
      send_b(mk_msg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                    $urandom_range(0, 255)));
    drain();

    // Asynchronous reset between edges with the FIFO full
    sink_mode_a = 0;
    @(posedge clk); #1;
    send_a(mk_msg(4, 0, 8'h21, 8'h77), 0);
    send_a(mk_msg(6, 0, 8'h22, 8'h88), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_out_val", 32'(out_val_a), 32'(0));
    check("arst_in_rdy", 32'(in_rdy_a), 32'(1));
    check("arst_num", 32'(num_entries_a), 32'(0));
    exp_q_a.delete();
    exp_q_b.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sink_mode_a = 1;
    send_a(mk_msg(7, 2, 8'hAA, 8'h3C), 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
